// File: rtl/vfifo_rd_ctrl.sv
// vfifo_rd_ctrl
// Read-side controller of the versatile FIFO. Everything here runs on the read
// clock. The Gray-coded write pointer is brought in through a two-flop
// synchroniser. Words are fetched from a dual-port RAM that has a registered
// read, and are captured into a 2-entry output buffer. The buffer is presented
// as a first-word-fall-through valid/ready stream. A registered Gray read
// pointer is returned to the write side.
//
// Ports:
//   clk          read-domain clock
//   rst          asynchronous active-high reset
//   wptr_gray_i  Gray write pointer from the write domain (asynchronous)
//   rptr_gray_o  Gray read pointer to the write domain (registered)
//   adr_b        RAM read address (RAM registers it; q_b is valid next cycle)
//   q_b          RAM read data
//   dout         head word of the output buffer
//   dout_valid   dout holds a valid word
//   dout_ready   consumer accepts dout when dout_valid is high
//   rd_level     words in RAM not yet fetched
module vfifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  output logic [ADDR_WIDTH:0]   rptr_gray_o,
  output logic [ADDR_WIDTH-1:0] adr_b,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   rd_level
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wsync1_reg;
  logic [PW-1:0]         wsync2_reg;
  logic [PW-1:0]         wsync_bin;
  logic [PW-1:0]         rptr_bin_reg;
  logic [1:0]            cnt_reg;     // output buffer occupancy, 0..2
  logic                  pend_reg;    // RAM read in flight: capture q_b this cycle
  logic [DATA_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] tail_reg;

  logic                  avail;
  logic                  pop;
  logic                  fetch;
  logic [2:0]            occ_after;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Written as a reduction per bit so there is no bit-to-bit combinational chain.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign wsync_bin[gi] = ^wsync2_reg[PW-1:gi];
    end
  endgenerate

  assign adr_b      = rptr_bin_reg[ADDR_WIDTH-1:0];
  assign avail      = (rptr_bin_reg != wsync_bin);
  assign dout_valid = (cnt_reg != 2'd0);
  assign dout       = head_reg;
  assign pop        = dout_valid & dout_ready;
  assign rd_level   = wsync_bin - rptr_bin_reg;

  // Occupancy the buffer will have once the in-flight word lands and any pop
  // retires. A new fetch is only issued if that leaves room for it, so
  // cnt + pend never exceeds 2.
  assign occ_after = {1'b0, cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
  assign fetch     = avail & (occ_after <= 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsync1_reg   <= '0;
      wsync2_reg   <= '0;
      rptr_bin_reg <= '0;
      rptr_gray_o  <= '0;
      cnt_reg      <= 2'd0;
      pend_reg     <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      wsync1_reg <= wptr_gray_i;
      wsync2_reg <= wsync1_reg;

      // The Gray pointer lags rptr_bin by one cycle. It therefore updates on
      // the same edge that captures the fetched word, after the RAM has
      // already registered that address, so the slot is safe to reuse.
      rptr_gray_o <= rptr_bin_reg ^ (rptr_bin_reg >> 1);

      if (fetch) begin
        rptr_bin_reg <= rptr_bin_reg + 1'b1;
      end
      pend_reg <= fetch;

      case ({pend_reg, pop})
        2'b11: begin
          // Head leaves and a new word arrives: shift and refill, count unchanged.
          if (cnt_reg == 2'd1) begin
            head_reg <= q_b;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= q_b;
          end
        end
        2'b10: begin
          if (cnt_reg == 2'd0) begin
            head_reg <= q_b;
          end else begin
            tail_reg <= q_b;
          end
          cnt_reg <= cnt_reg + 2'd1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          cnt_reg  <= cnt_reg - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
